// File: rtl/muldiv_pkg.sv
// Shared types and constants for the EX-stage iterative multiply/divide sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: op encodings for MUL*/DIV*/REM*, FSM state encoding, iteration
// counter width, datapath width and the flush/boolean level constants.
package muldiv_pkg;

  localparam int XLEN  = 32;
  localparam int ITER  = 32;
  localparam int CNT_W = 6;

  localparam logic FLUSH = 1'b1;
  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  typedef enum logic [1:0] {
    MUL_OP_MUL    = 2'd0,
    MUL_OP_MULH   = 2'd1,
    MUL_OP_MULHSU = 2'd2,
    MUL_OP_MULHU  = 2'd3
  } mul_op_e;

  // Bit 0 set = unsigned, bit 1 set = remainder.
  typedef enum logic [1:0] {
    DIV_OP_DIV  = 2'd0,
    DIV_OP_DIVU = 2'd1,
    DIV_OP_REM  = 2'd2,
    DIV_OP_REMU = 2'd3
  } div_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/muldiv_iter_core.sv
// One-bit-per-cycle shift-add multiplier / restoring divider datapath.
// Latency: one iteration per step cycle; acc_nxt_o shows the post-step value combinationally.
// Backpressure: none; advances only when step_i is high, controlled entirely by the sequencer.
//
// Ports:
//   clk, rst_n      clock, async active-low reset
//   load_i          load magnitudes a_i/b_i (class chosen by is_div_i)
//   step_i          perform one iteration
//   is_div_i        1 = restoring divide, 0 = shift-add multiply
//   a_i, b_i        unsigned operand magnitudes (dividend/multiplicand, divisor/multiplier)
//   acc_nxt_o       accumulator after the current step: mul {hi,lo} product, div {rem,quo}
module muldiv_iter_core #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              step_i,
  input  logic              is_div_i,
  input  logic [XLEN-1:0]   a_i,
  input  logic [XLEN-1:0]   b_i,
  output logic [2*XLEN-1:0] acc_nxt_o
);

  // Mul: acc = {partial high, multiplier shifting out}; opnd = multiplicand.
  // Div: acc = {partial remainder, dividend shifting into quotient}; opnd = divisor.
  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   opnd_q;

  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_nxt;
  logic [XLEN:0]     div_sh;
  logic              div_ge;
  logic [XLEN-1:0]   div_sub;
  logic [2*XLEN-1:0] div_nxt;

  always_comb begin
    mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
    mul_nxt = {mul_sum, acc_q[XLEN-1:1]};

    // Shift the next dividend bit into the partial remainder and trial-subtract.
    // When the subtraction succeeds the difference is below the divisor, so
    // the low XLEN bits of the difference are exact.
    div_sh  = acc_q[2*XLEN-1:XLEN-1];
    div_ge  = (div_sh >= {1'b0, opnd_q});
    div_sub = div_sh[XLEN-1:0] - opnd_q;
    div_nxt = {(div_ge ? div_sub : div_sh[XLEN-1:0]), acc_q[XLEN-2:0], div_ge};

    acc_nxt_o = is_div_i ? div_nxt : mul_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      opnd_q <= '0;
    end else if (load_i) begin
      acc_q  <= {{XLEN{1'b0}}, (is_div_i ? a_i : b_i)};
      opnd_q <= is_div_i ? b_i : a_i;
    end else if (step_i) begin
      acc_q  <= acc_nxt_o;
    end
  end

endmodule

// File: rtl/ex_muldiv_ctrl.sv
// EX-stage sequencer for the shared iterative mul/div unit (IDLE -> RUN x32 -> DONE).
// Latency: start seen in cycle N, done from N+33 (N+1 for early-out cases when enabled).
// Backpressure: result and done held in DONE until mem_allowin; pipe_flush aborts in any state.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   pipe_flush                 abort current operation (level FLUSH)
//   ex_valid, ex_is_mul_inst,
//   ex_is_div_inst             EX holds a valid MUL* / DIV*-REM* instruction (mul wins if both)
//   ex_mul_op, ex_div_op       op codes (see muldiv_pkg)
//   ex_rs1, ex_rs2             operands A (dividend) and B (divisor)
//   mem_allowin                MEM accepts the handoff this cycle
//   ex_mul_done, ex_div_done   result ready, decoded from registered state
//   ex_muldiv_res              registered result
//   muldiv_busy                FSM not in IDLE
//
// Build option: MULDIV_EARLY_OUT_EN - divide-by-zero, signed overflow, unsigned
// divisor > dividend and multiply-by-zero go straight to DONE with the final result.
module ex_muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pipe_flush,
  input  logic            ex_valid,
  input  logic            ex_is_mul_inst,
  input  logic            ex_is_div_inst,
  input  logic [1:0]      ex_mul_op,
  input  logic [1:0]      ex_div_op,
  input  logic [XLEN-1:0] ex_rs1,
  input  logic [XLEN-1:0] ex_rs2,
  input  logic            mem_allowin,
  output logic            ex_mul_done,
  output logic            ex_div_done,
  output logic [XLEN-1:0] ex_muldiv_res,
  output logic            muldiv_busy
);

  localparam logic [CNT_W-1:0] ITER_LAST = CNT_W'(ITER - 1);
  localparam logic [XLEN-1:0]  MIN_NEG   = {1'b1, {(XLEN-1){1'b0}}};

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              is_mul_q;
  logic [1:0]        op_q;
  logic              neg_q;     // product / quotient needs negation
  logic              sa_q;      // dividend sign, gives remainder sign
  logic              dz_q;
  logic              ovf_q;
  logic [XLEN-1:0]   rs1_q;     // raw dividend for the divide-by-zero remainder
  logic [XLEN-1:0]   res_q;

  // Start-cycle decode
  logic              flush_c;
  logic              start_c;
  logic              st_mul;
  logic [1:0]        st_op;
  logic              a_sgn, b_sgn;
  logic              st_sa, st_sb;
  logic [XLEN-1:0]   a_abs, b_abs;
  logic              st_dz, st_ovf;
  logic              early_c;
  logic [XLEN-1:0]   early_res;

  // Final-iteration result
  logic [2*XLEN-1:0] acc_nxt;
  logic [2*XLEN-1:0] prod_c;
  logic [XLEN-1:0]   quo_c, rem_c;
  logic [XLEN-1:0]   fin_res;

  logic              core_load, core_step, core_is_div;

  always_comb begin
    flush_c = (pipe_flush == FLUSH);
    start_c = ex_valid && (ex_is_mul_inst || ex_is_div_inst) && !flush_c;
    st_mul  = ex_is_mul_inst;
    st_op   = st_mul ? ex_mul_op : ex_div_op;

    // MULHSU keeps rs2 unsigned; DIVU/REMU have bit 0 set.
    a_sgn = st_mul ? (st_op != MUL_OP_MULHU) : !st_op[0];
    b_sgn = st_mul ? ((st_op == MUL_OP_MUL) || (st_op == MUL_OP_MULH)) : !st_op[0];
    st_sa = a_sgn & ex_rs1[XLEN-1];
    st_sb = b_sgn & ex_rs2[XLEN-1];
    a_abs = st_sa ? -ex_rs1 : ex_rs1;
    b_abs = st_sb ? -ex_rs2 : ex_rs2;

    st_dz  = !st_mul && (ex_rs2 == '0);
    st_ovf = !st_mul && !st_op[0] && (ex_rs1 == MIN_NEG) && (ex_rs2 == '1);

`ifdef MULDIV_EARLY_OUT_EN
    early_c   = 1'b0;
    early_res = '0;
    if (st_mul) begin
      early_c = (ex_rs1 == '0) || (ex_rs2 == '0);
    end else if (st_dz) begin
      early_c   = 1'b1;
      early_res = st_op[1] ? ex_rs1 : '1;
    end else if (st_ovf) begin
      early_c   = 1'b1;
      early_res = st_op[1] ? '0 : MIN_NEG;
    end else if (st_op[0] && (ex_rs2 > ex_rs1)) begin
      early_c   = 1'b1;
      early_res = st_op[1] ? ex_rs1 : '0;
    end
`else
    early_c   = 1'b0;
    early_res = '0;
`endif
  end

  // Sign correction applied to the value the core produces on its last step.
  always_comb begin
    prod_c = neg_q ? -acc_nxt : acc_nxt;
    quo_c  = neg_q ? -acc_nxt[XLEN-1:0] : acc_nxt[XLEN-1:0];
    rem_c  = sa_q  ? -acc_nxt[2*XLEN-1:XLEN] : acc_nxt[2*XLEN-1:XLEN];

    if (is_mul_q) begin
      fin_res = (op_q == MUL_OP_MUL) ? prod_c[XLEN-1:0] : prod_c[2*XLEN-1:XLEN];
    end else if (dz_q) begin
      fin_res = op_q[1] ? rs1_q : '1;
    end else if (ovf_q) begin
      fin_res = op_q[1] ? '0 : MIN_NEG;
    end else begin
      fin_res = op_q[1] ? rem_c : quo_c;
    end
  end

  always_comb begin
    core_load   = (state_q == ST_IDLE) && start_c && !early_c;
    core_step   = (state_q == ST_RUN) && !flush_c;
    core_is_div = (state_q == ST_IDLE) ? !st_mul : !is_mul_q;
  end

  muldiv_iter_core #(.XLEN(XLEN)) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (core_load),
    .step_i    (core_step),
    .is_div_i  (core_is_div),
    .a_i       (a_abs),
    .b_i       (b_abs),
    .acc_nxt_o (acc_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      is_mul_q <= 1'b0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      sa_q     <= 1'b0;
      dz_q     <= 1'b0;
      ovf_q    <= 1'b0;
      rs1_q    <= '0;
      res_q    <= '0;
    end else if (flush_c) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_c) begin
            is_mul_q <= st_mul;
            op_q     <= st_op;
            neg_q    <= st_sa ^ st_sb;
            sa_q     <= st_sa;
            dz_q     <= st_dz;
            ovf_q    <= st_ovf;
            rs1_q    <= ex_rs1;
            cnt_q    <= '0;
            if (early_c) begin
              res_q   <= early_res;
              state_q <= ST_DONE;
            end else begin
              state_q <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == ITER_LAST) begin
            res_q   <= fin_res;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (mem_allowin) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ex_mul_done   = (state_q == ST_DONE) &&  is_mul_q;
  assign ex_div_done   = (state_q == ST_DONE) && !is_mul_q;
  assign muldiv_busy   = (state_q != ST_IDLE);
  assign ex_muldiv_res = res_q;

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Directed, table-driven bench for ex_muldiv_ctrl.
// Latency: checks done arrival cycle per vector (33, or 1 for early-out cases when enabled).
// Backpressure: exercises DONE hold under mem_allowin=0, flush abort and async reset.
module tb_ex_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pipe_flush;
  logic        ex_valid;
  logic        ex_is_mul_inst;
  logic        ex_is_div_inst;
  logic [1:0]  ex_mul_op;
  logic [1:0]  ex_div_op;
  logic [31:0] ex_rs1;
  logic [31:0] ex_rs2;
  logic        mem_allowin;
  logic        ex_mul_done;
  logic        ex_div_done;
  logic [31:0] ex_muldiv_res;
  logic        muldiv_busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ex_muldiv_ctrl #(.XLEN(32), .ITER(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pipe_flush    (pipe_flush),
    .ex_valid      (ex_valid),
    .ex_is_mul_inst(ex_is_mul_inst),
    .ex_is_div_inst(ex_is_div_inst),
    .ex_mul_op     (ex_mul_op),
    .ex_div_op     (ex_div_op),
    .ex_rs1        (ex_rs1),
    .ex_rs2        (ex_rs2),
    .mem_allowin   (mem_allowin),
    .ex_mul_done   (ex_mul_done),
    .ex_div_done   (ex_div_done),
    .ex_muldiv_res (ex_muldiv_res),
    .muldiv_busy   (muldiv_busy)
  );

  typedef struct {
    logic        is_mul;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic        early;
  } vec_t;

  localparam int NVEC = 19;
  vec_t vecs[NVEC];

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive_op(input logic is_mul, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    ex_valid       = 1'b1;
    ex_is_mul_inst = is_mul;
    ex_is_div_inst = !is_mul;
    ex_mul_op      = op;
    ex_div_op      = op;
    ex_rs1         = a;
    ex_rs2         = b;
  endtask

  // Returns the number of posedges from the start-capturing edge to the
  // first negedge at which a done output is high (bounded).
  task automatic wait_done(output int cyc);
    cyc = 1;
    while (!(ex_mul_done || ex_div_done) && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic run_op(input vec_t v, input int idx);
    int cyc;
    int exp_lat;
`ifdef MULDIV_EARLY_OUT_EN
    exp_lat = v.early ? 1 : 33;
`else
    exp_lat = 33;
`endif
    @(negedge clk);
    drive_op(v.is_mul, v.op, v.a, v.b);
    mem_allowin = 1'b1;
    @(negedge clk);
    ex_valid = 1'b0;
    wait_done(cyc);
    chk("latency", idx, 32'(cyc), 32'(exp_lat));
    chk("done_class", idx, {30'd0, ex_mul_done, ex_div_done}, v.is_mul ? 32'd2 : 32'd1);
    chk("result", idx, ex_muldiv_res, v.exp);
    chk("busy_in_done", idx, {31'd0, muldiv_busy}, 32'd1);
    @(negedge clk);
    chk("done_after_handoff", idx, {30'd0, ex_mul_done, ex_div_done}, 32'd0);
    chk("busy_after_handoff", idx, {31'd0, muldiv_busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   cyc;
    int   seen;
    vec_t v;

    //            mul   op    a             b             expected      early
    vecs[0]  = '{1'b1, 2'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0};
    vecs[1]  = '{1'b1, 2'd1, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0};
    vecs[2]  = '{1'b1, 2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0};
    vecs[3]  = '{1'b1, 2'd2, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 1'b0};
    vecs[4]  = '{1'b0, 2'd0, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0};
    vecs[5]  = '{1'b0, 2'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0};
    vecs[6]  = '{1'b0, 2'd1, 32'd5,        32'd0,        32'hFFFFFFFF, 1'b1};
    vecs[7]  = '{1'b0, 2'd3, 32'd5,        32'd0,        32'd5,        1'b1};
    vecs[8]  = '{1'b0, 2'd0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1};
    vecs[9]  = '{1'b0, 2'd2, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1'b1};
    vecs[10] = '{1'b0, 2'd1, 32'd100,      32'd7,        32'd14,       1'b0};
    vecs[11] = '{1'b0, 2'd3, 32'd3,        32'd10,       32'd3,        1'b1};
    vecs[12] = '{1'b1, 2'd0, 32'd0,        32'd5,        32'd0,        1'b1};
    vecs[13] = '{1'b0, 2'd0, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0};
    vecs[14] = '{1'b0, 2'd2, 32'd7,        32'hFFFFFFFE, 32'd1,        1'b0};
    vecs[15] = '{1'b1, 2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        1'b0};
    vecs[16] = '{1'b1, 2'd0, 32'h12345678, 32'h00000010, 32'h23456780, 1'b0};
    vecs[17] = '{1'b0, 2'd0, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 1'b1};
    vecs[18] = '{1'b0, 2'd2, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 1'b1};

    rst_n          = 1'b0;
    pipe_flush     = 1'b0;
    ex_valid       = 1'b0;
    ex_is_mul_inst = 1'b0;
    ex_is_div_inst = 1'b0;
    ex_mul_op      = 2'd0;
    ex_div_op      = 2'd0;
    ex_rs1         = '0;
    ex_rs2         = '0;
    mem_allowin    = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_res", 0, ex_muldiv_res, 32'd0);
    chk("rst_done", 0, {30'd0, ex_mul_done, ex_div_done}, 32'd0);
    chk("rst_busy", 0, {31'd0, muldiv_busy}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", 0, {31'd0, muldiv_busy}, 32'd0);

    for (int i = 0; i < NVEC; i++) begin
      run_op(vecs[i], i);
    end

    // DONE held under backpressure, then released with no restart.
    @(negedge clk);
    drive_op(1'b0, 2'd0, 32'hFFFFFFF9, 32'd2);
    mem_allowin = 1'b0;
    @(negedge clk);
    wait_done(cyc);
    chk("hold_latency", 100, 32'(cyc), 32'd33);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("hold_div_done", 100 + k, {31'd0, ex_div_done}, 32'd1);
      chk("hold_res", 100 + k, ex_muldiv_res, 32'hFFFFFFFD);
      chk("hold_busy", 100 + k, {31'd0, muldiv_busy}, 32'd1);
    end
    mem_allowin = 1'b1;
    ex_valid    = 1'b0;
    @(negedge clk);
    chk("release_done", 110, {30'd0, ex_mul_done, ex_div_done}, 32'd0);
    chk("release_busy", 110, {31'd0, muldiv_busy}, 32'd0);
    @(negedge clk);
    chk("no_restart_busy", 111, {31'd0, muldiv_busy}, 32'd0);

    // Flush at RUN cycle 15 aborts; done never rises.
    @(negedge clk);
    drive_op(1'b0, 2'd1, 32'd100, 32'd7);
    @(negedge clk);
    ex_valid = 1'b0;
    cyc = 1;
    while (cyc < 15) begin
      @(negedge clk);
      cyc++;
    end
    chk("run_busy_before_flush", 200, {31'd0, muldiv_busy}, 32'd1);
    pipe_flush = 1'b1;
    @(negedge clk);
    pipe_flush = 1'b0;
    chk("flush_busy", 200, {31'd0, muldiv_busy}, 32'd0);
    chk("flush_done", 200, {30'd0, ex_mul_done, ex_div_done}, 32'd0);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ex_mul_done || ex_div_done) seen = 1;
    end
    chk("flush_no_done", 200, 32'(seen), 32'd0);
    v = '{1'b0, 2'd1, 32'd100, 32'd7, 32'd14, 1'b0};
    run_op(v, 201);

    // Asynchronous reset in the middle of RUN.
    @(negedge clk);
    drive_op(1'b1, 2'd0, 32'd7, 32'hFFFFFFFD);
    @(negedge clk);
    ex_valid = 1'b0;
    repeat (5) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_busy", 300, {31'd0, muldiv_busy}, 32'd0);
    chk("async_rst_res", 300, ex_muldiv_res, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("after_rst_busy", 301, {31'd0, muldiv_busy}, 32'd0);
    chk("after_rst_done", 301, {30'd0, ex_mul_done, ex_div_done}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_ctrl.md
# ex_muldiv_ctrl

Sequencer for a shared iterative multiply/divide unit in EX. Accepts a mul or div instruction held in EX, runs a 32-iteration shift-add or restoring-divide loop, and raises `ex_mul_done`/`ex_div_done` to the EX/MEM stage register's ready-go logic. The result is held until the EX/MEM stage register accepts it. Pipe flush aborts the operation.

## Interface
Parameters:
- `XLEN`, 32: operand and result width. Only 32 is supported.
- `ITER`, 32: loop iterations. Must equal `XLEN`.

Ports. Clock and reset are fixed: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- `clk` in 1: core clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `pipe_flush` in 1: abort the current operation (`FLUSH` level).
- `ex_valid` in 1: the EX stage holds a valid instruction.
- `ex_is_mul_inst` in 1: the EX instruction is MUL*.
- `ex_is_div_inst` in 1: the EX instruction is DIV*/REM*.
- `ex_mul_op` in 2: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU.
- `ex_div_op` in 2: 0 DIV, 1 DIVU, 2 REM, 3 REMU.
- `ex_rs1` in XLEN: operand A (dividend).
- `ex_rs2` in XLEN: operand B (divisor).
- `mem_allowin` in 1: the MEM stage accepts a handoff this cycle.
- `ex_mul_done` out 1: the mul result is ready.
- `ex_div_done` out 1: the div result is ready.
- `ex_muldiv_res` out XLEN: the final result, valid while either done output is high.
- `muldiv_busy` out 1: the FSM is not in IDLE.

## Operation
The FSM has three states: IDLE, RUN, DONE.

IDLE:
- Start condition: `ex_valid && (ex_is_mul_inst || ex_is_div_inst)` with no flush.
- If both op flags are high, mul wins.
- On start, latch the op class (mul/div), the op code, and the operand signs.
- Load absolute values according to op signedness. MULHSU treats rs2 as unsigned.
- Clear the 6-bit iteration counter, then go to RUN.

RUN:
- Each cycle performs one iteration.
  - Mul: shift-add into a 2·XLEN accumulator.
  - Div: restoring subtract/shift, producing quotient and remainder.
- When the counter reaches ITER−1, apply sign correction, register the result, and go to DONE.

Sign correction rules:
- MUL: low half. MULH*: high half of the two's-complement-corrected product.
- Signed DIV: quotient is negated if the operand signs differ.
- Signed REM: remainder takes the dividend's sign.

Special cases always produce RISC-V results:
- Divide by zero: quotient = all ones, remainder = rs1.
- Signed overflow (0x80000000 / −1): quotient = 0x80000000, remainder = 0.
- These are detected at start and latched.

DONE:
- `ex_mul_done` or `ex_div_done` (per the latched class) is high and the result is stable.
- Exit to IDLE only when `mem_allowin` is high, which is the handoff cycle.
- Otherwise stay in DONE with outputs held. No restart of the same instruction.

Flush:
- `pipe_flush` in any state goes to IDLE next cycle.
- Done outputs go low next cycle. Datapath registers are don't-care.
- Flush has priority over start and handoff.
- No start is possible in the cycle after a flush unless `ex_valid` is high again.

Reset mid-operation: return to IDLE immediately (asynchronous).

## Timing
- Reset values: all outputs 0; state IDLE; result register 0; counter 0.
- Nominal latency: start observed in cycle N. RUN occupies N+1…N+32. Done is high from N+33.
- Done outputs and `muldiv_busy` are decoded from registered state only; there is no combinational path from inputs.
- Handoff: done && `mem_allowin` in cycle M gives IDLE at M+1, with done low at M+1.
  - A new mul/div instruction then in EX starts at M+1.
  - Back-to-back operation spacing is therefore 34 cycles.
- `mem_allowin` low while in DONE: hold indefinitely.
- `mem_allowin` toggling during RUN: no effect.

## Configuration
- `MULDIV_EARLY_OUT_EN` defined:
  - Divide-by-zero, signed overflow, and unsigned divisor > dividend (quotient 0, remainder = rs1) go IDLE→DONE directly.
  - Done is high at N+1.
  - Multiply by zero also early-outs with result 0.
- `MULDIV_EARLY_OUT_EN` undefined: every operation takes the full 33 cycles. Special-case results are identical.

## Structure
Shared package (`muldiv_pkg`) holds:
- the mul/div op encodings;
- the FSM state encoding;
- the counter width (6);
- `XLEN`, `FLUSH`, `TRUE`/`FALSE`, taken from `defines.v`.

Sub-module `muldiv_iter_core`:
- contains the accumulator, the quotient/remainder registers, and the one-iteration step logic;
- is controlled by `load`/`step`/`is_div` from the FSM;
- keeps the sign handling and the FSM in the top level.

## Test plan
- MUL 7×−3 with `mem_allowin`=1: `ex_mul_done` rises exactly 33 cycles after start; res = 0xFFFFFFEB; done low the next cycle.
- MULH 0x80000000×0x80000000 gives res 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF gives 0xFFFFFFFE.
- DIV −7/2 gives −3 (0xFFFFFFFD); REM −7/2 gives 0xFFFFFFFF.
- Divide-by-zero and signed-overflow results:
  - DIVU 5/0 gives 0xFFFFFFFF.
  - DIV 0x80000000/−1 gives 0x80000000; REM of the same gives 0.
  - With `MULDIV_EARLY_OUT_EN`, done arrives at N+1.
- `mem_allowin` held 0 for 10 cycles after done: `ex_div_done` and res stay stable; on release, IDLE next cycle and no restart.
- `pipe_flush` at RUN cycle 15: IDLE next cycle, done never rises. A new DIVU 100/7 then gives 14 after 33 cycles.
